// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that shares one uart_tx among N
// byte-producing requesters, with a watchdog that aborts a transfer when the
// transmitter never reports completion.
//
// Handshake: req[i] is a level request; requester i holds req[i] high and
// data_in[i*DBIT +: DBIT] stable until it sees ack[i] for one cycle. req is
// only sampled in IDLE, so a requester that drops req after being granted
// still gets its byte sent and still receives ack. Towards uart_tx, tx_start
// is a one-cycle pulse; tx_din stays stable until tx_done_tick (or a timeout).
//
// Optional feature: define UART_SCHED_TAG_EN to send a tag byte
// {4'hA, 1'b0, grant_id} before each data byte (TAG_START/TAG_WAIT states).
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req, data_in        per-requester request levels and packed bytes
//   ack, err            one-cycle completion pulse / timeout flag
//   busy, grant_id      not-IDLE indicator, current or last granted index
//   tx_start, tx_din    start pulse and byte to uart_tx
//   tx_done_tick        completion pulse from uart_tx
//   o_state             FSM state, for debug and checkers
module uart_tx_sched #(
    parameter int N       = 4,
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 65535,
    parameter int TO_BIT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [N*DBIT-1:0] data_in,
    output logic [N-1:0]      ack,
    output logic              err,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din,
    input  logic              tx_done_tick,
    output logic [2:0]        o_state
);

`ifdef UART_SCHED_TAG_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT      = 3'd2,
        S_DONE      = 3'd3,
        S_TAG_START = 3'd4,
        S_TAG_WAIT  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3
    } state_t;
`endif

    // Watchdog fires on the cycle whose increment would reach TIMEOUT, so the
    // abort lands TIMEOUT cycles after the last START/TAG_START cycle.
    localparam logic [TO_BIT-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_BIT'(TIMEOUT - 1);

    state_t            r_state;
    logic [2:0]        r_grant_id;
    logic              r_tx_start;
    logic [DBIT-1:0]   r_tx_din;
    logic [N-1:0]      r_ack;
    logic              r_err;
    logic [TO_BIT-1:0] r_wd;
`ifdef UART_SCHED_TAG_EN
    logic [DBIT-1:0]   r_hold;
`endif

    logic              w_found;
    logic [2:0]        w_winner;
    logic [DBIT-1:0]   w_byte;
    logic              w_timeout;
    logic [N-1:0]      w_onehot;

    // Cyclic search starting one past the last grant; k = N wraps back to the
    // last granted requester itself, so it is considered last.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = r_grant_id;
        w_byte   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(r_grant_id) + k) % N;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = 3'(idx);
                w_byte   = data_in[idx*DBIT +: DBIT];
            end
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_wd == TO_LAST);
    assign w_onehot  = N'(1) << r_grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant_id <= 3'(N - 1);
            r_tx_start <= 1'b0;
            r_tx_din   <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_wd       <= '0;
`ifdef UART_SCHED_TAG_EN
            r_hold     <= '0;
`endif
        end else begin
            // Pulse outputs default low; each is raised on the transition into
            // the state where it must be visible.
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_tx_start <= 1'b1;
`ifdef UART_SCHED_TAG_EN
                        r_hold     <= w_byte;
                        r_tx_din   <= DBIT'({4'hA, 1'b0, w_winner});
                        r_state    <= S_TAG_START;
`else
                        r_tx_din   <= w_byte;
                        r_state    <= S_START;
`endif
                    end
                end
`ifdef UART_SCHED_TAG_EN
                S_TAG_START: begin
                    r_wd    <= '0;
                    r_state <= S_TAG_WAIT;
                end
                S_TAG_WAIT: begin
                    if (tx_done_tick) begin
                        r_tx_din   <= r_hold;
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end else if (w_timeout) begin
                        // A dead tag skips the data byte entirely.
                        r_ack   <= w_onehot;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wd <= r_wd + TO_BIT'(1);
                    end
                end
`endif
                S_START: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion has priority over a simultaneous timeout.
                    if (tx_done_tick) begin
                        r_ack   <= w_onehot;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_ack   <= w_onehot;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wd <= r_wd + TO_BIT'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant_id;
    assign tx_start = r_tx_start;
    assign tx_din   = r_tx_din;
    assign o_state  = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched. The uart_tx side is modelled by tasks
// that wait for tx_start and answer with tx_done_tick after a chosen delay.
// Inputs change #1 after the rising edge; outputs are sampled at that point.
module tb_uart_tx_sched;
    localparam int N       = 4;
    localparam int DBIT    = 8;
    localparam int TIMEOUT = 50;
    localparam int TO_BIT  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*DBIT-1:0] data_in;
    logic [N-1:0]      ack;
    logic              err;
    logic              busy;
    logic [2:0]        grant_id;
    logic              tx_start;
    logic [DBIT-1:0]   tx_din;
    logic              tx_done_tick;
    logic [2:0]        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_sched #(
        .N(N), .DBIT(DBIT), .TIMEOUT(TIMEOUT), .TO_BIT(TO_BIT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
        .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
        .o_state(state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1; req = '0; data_in = '0; tx_done_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Looks at the current cycle first, then advances one edge at a time.
    task automatic wait_start(output bit ok, output int lat, output logic [DBIT-1:0] b);
        ok = 1'b0; lat = 0; b = '0;
        for (int i = 0; i < 100; i++) begin
            if (tx_start) begin
                ok = 1'b1; lat = i; b = tx_din;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // tx_done_tick high during the cycle `delay` cycles after tx_start;
    // returns in the cycle after that (DONE, or the data START with tags).
    task automatic pulse_done(input int delay);
        repeat (delay) @(posedge clk);
        #1 tx_done_tick = 1'b1;
        @(posedge clk);
        #1 tx_done_tick = 1'b0;
    endtask

    task automatic serve_grant(input int delay, output bit ok, output int lat,
                               output logic [7:0] tag, output int gap,
                               output logic [N-1:0] mid_ack, output logic [DBIT-1:0] data);
        bit ok2;
        logic [DBIT-1:0] b;
        ok2 = 1'b1;
        wait_start(ok, lat, b);
`ifdef UART_SCHED_TAG_EN
        tag = b;
        pulse_done(delay);
        mid_ack = ack;
        wait_start(ok2, gap, data);
`else
        tag = '0; gap = 0; mid_ack = '0; data = b;
`endif
        ok = ok && ok2;
        pulse_done(delay);
    endtask

    task automatic wait_ack(output bit ok, output int n);
        ok = 1'b0; n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                ok = 1'b1; n = i;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_checks++; if (tx_din !== 8'h00) begin n_fail++; $display("FAIL reset_tx_din: got %h expected 00", tx_din); end
        n_checks++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 3", grant_id); end
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_single();
        bit ok; int lat; int gap; logic [7:0] tag; logic [N-1:0] mid; logic [DBIT-1:0] d;
        req = 4'b0001; data_in = {24'h0, 8'h55};
        serve_grant(20, ok, lat, tag, gap, mid, d);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_start_seen: got %b expected 1", ok); end
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", lat); end
        n_checks++; if (d !== 8'h55) begin n_fail++; $display("FAIL single_tx_din: got %h expected 55", d); end
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", ack); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", err); end
        n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL single_grant_id: got %0d expected 0", grant_id); end
`ifdef UART_SCHED_TAG_EN
        n_checks++; if (tag !== 8'hA0) begin n_fail++; $display("FAIL single_tag: got %h expected a0", tag); end
`endif
        req = '0;
        @(posedge clk); #1;
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_clear: got %b expected 0000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        bit ok; int lat; int gap; logic [7:0] tag; logic [N-1:0] mid; logic [DBIT-1:0] d;
        logic [DBIT-1:0] exp_q[$];
        logic [N-1:0]    exp_ack_q[$];
        logic [DBIT-1:0] eb;
        logic [N-1:0]    ea;
        exp_q     = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
        exp_ack_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; data_in = {8'h40, 8'h30, 8'h20, 8'h10};
        for (int g = 0; g < 5; g++) begin
            serve_grant(3, ok, lat, tag, gap, mid, d);
            eb = exp_q.pop_front();
            ea = exp_ack_q.pop_front();
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_start_seen[%0d]: got %b expected 1", g, ok); end
            n_checks++; if (d !== eb) begin n_fail++; $display("FAIL rr_byte[%0d]: got %h expected %h", g, d, eb); end
            n_checks++; if (ack !== ea) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", g, ack, ea); end
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err[%0d]: got %b expected 0", g, err); end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        bit ok; int lat; int gap; logic [7:0] tag; logic [N-1:0] mid; logic [DBIT-1:0] d;
        req = 4'b1000; data_in = {8'hD3, 16'h0, 8'hD0};
        serve_grant(4, ok, lat, tag, gap, mid, d);
        n_checks++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL wrap_setup_grant: got %0d expected 3", grant_id); end
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_setup_ack: got %b expected 1000", ack); end
        req = 4'b1001;
        serve_grant(4, ok, lat, tag, gap, mid, d);
        n_checks++; if (d !== 8'hD0) begin n_fail++; $display("FAIL wrap_first_byte: got %h expected d0", d); end
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL wrap_first_ack: got %b expected 0001", ack); end
        serve_grant(4, ok, lat, tag, gap, mid, d);
        n_checks++; if (d !== 8'hD3) begin n_fail++; $display("FAIL wrap_second_byte: got %h expected d3", d); end
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL wrap_second_ack: got %b expected 1000", ack); end
        req = '0;
    endtask

    task automatic test_timeout();
        bit ok; int lat; int n; logic [DBIT-1:0] b;
        req = 4'b0100; data_in = {8'h00, 8'h77, 16'h0};
        wait_start(ok, lat, b);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_start_seen: got %b expected 1", ok); end
`ifdef UART_SCHED_TAG_EN
        n_checks++; if (b !== 8'hA2) begin n_fail++; $display("FAIL to_first_byte: got %h expected a2", b); end
`else
        n_checks++; if (b !== 8'h77) begin n_fail++; $display("FAIL to_first_byte: got %h expected 77", b); end
`endif
        wait_ack(ok, n);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_ack_seen: got %b expected 1", ok); end
        n_checks++; if (n !== 51) begin n_fail++; $display("FAIL to_ack_delay: got %0d expected 51", n); end
        n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL to_ack: got %b expected 0100", ack); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", err); end
        req = '0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy_after: got %b expected 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_after: got %b expected 0", err); end
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL to_state_after: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; int gap; logic [7:0] tag; logic [N-1:0] mid; logic [DBIT-1:0] d;
        req = 4'b0010; data_in = {16'h0, 8'h99, 8'h00};
        wait_start(ok, lat, d);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack: got %b expected 0000", ack); end
        n_checks++; if (tx_din !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_din: got %h expected 00", tx_din); end
        n_checks++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL rstmid_grant_id: got %0d expected 3", grant_id); end
        n_checks++; if (state_dbg !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", state_dbg); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        serve_grant(5, ok, lat, tag, gap, mid, d);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rstmid_relatency: got %0d expected 1", lat); end
        n_checks++; if (d !== 8'h99) begin n_fail++; $display("FAIL rstmid_byte: got %h expected 99", d); end
        n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL rstmid_ack_after: got %b expected 0010", ack); end
        n_checks++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL rstmid_grant_after: got %0d expected 1", grant_id); end
        req = '0;
        @(posedge clk); #1;
    endtask

`ifdef UART_SCHED_TAG_EN
    task automatic test_tag();
        bit ok; int lat; int gap; logic [7:0] tag; logic [N-1:0] mid; logic [DBIT-1:0] d;
        req = 4'b0100; data_in = {8'h00, 8'hC3, 16'h0};
        serve_grant(6, ok, lat, tag, gap, mid, d);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tag_starts_seen: got %b expected 1", ok); end
        n_checks++; if (tag !== 8'hA2) begin n_fail++; $display("FAIL tag_byte: got %h expected a2", tag); end
        n_checks++; if (gap !== 0) begin n_fail++; $display("FAIL tag_gap: got %0d expected 0", gap); end
        n_checks++; if (mid !== 4'b0000) begin n_fail++; $display("FAIL tag_mid_ack: got %b expected 0000", mid); end
        n_checks++; if (d !== 8'hC3) begin n_fail++; $display("FAIL tag_data_byte: got %h expected c3", d); end
        n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL tag_ack: got %b expected 0100", ack); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tag_err: got %b expected 0", err); end
        req = '0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_reset_mid();
`ifdef UART_SCHED_TAG_EN
        test_tag();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
